spi_byte_sequencer: RTL and testbench

SPI_BYTE_SEQUENCER -- requirements
Module: spi_byte_sequencer

---
 rtl/spi_byte_sequencer_if.sv | 29 ++
 rtl/spi_byte_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_byte_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_sequencer_if.sv
// Purpose: byte-stream and spi_master handshake bundle for spi_byte_sequencer.
// Latency: pure wiring, no state.
// Backpressure: tx_ready/rx_ready valid-ready pairs; spi_start/spi_finish pulse handshake.
interface spi_byte_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_ready;
  logic                  spi_start;
  logic [DATA_WIDTH-1:0] spi_data_in;
  logic                  spi_finish;
  logic [DATA_WIDTH-1:0] spi_data_out;

  // Sequencer side of the bundle.
  modport slave (
    input  tx_valid, tx_data, rx_ready, spi_finish, spi_data_out,
    output tx_ready, rx_valid, rx_data, spi_start, spi_data_in
  );

  // Environment side: upstream producer, downstream consumer and spi_master.
  modport master (
    output tx_valid, tx_data, rx_ready, spi_finish, spi_data_out,
    input  tx_ready, rx_valid, rx_data, spi_start, spi_data_in
  );
endinterface

// File: rtl/spi_byte_sequencer.sv
// Purpose: queues TX words, runs them one at a time through spi_master, queues replies.
// Latency: push to spi_start >= 2 cycles; spi_finish edge to RX push 1 cycle; 3+GAP_CYCLES overhead per word.
// Backpressure: tx_ready drops when TX FIFO full; sequencer stalls in IDLE while RX FIFO full.

// Show-ahead FIFO with level-derived full/empty; push at full is taken only with a pop.
module spi_byte_sequencer_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally (power-of-2 depth); level tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

module spi_byte_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  spi_byte_sequencer_if.slave          bus,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  tx_level,
  output logic [$clog2(FIFO_DEPTH):0]  rx_level,
  output logic                         err_timeout,
  input  logic                         err_clr
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_CAPTURE,
    ST_GAP
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  rdy_en_q;
  logic                  spi_start_q;
  logic [DATA_WIDTH-1:0] spi_data_in_q;
  logic                  fin_prev_q;
  logic [TW-1:0]         tmo_cnt_q;
  logic [GW-1:0]         gap_cnt_q;
  logic                  err_q;

  logic                  tx_push;
  logic                  tx_pop;
  logic [DATA_WIDTH-1:0] tx_head;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  rx_push;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  fin_rise;

  assign bus.tx_ready = rdy_en_q && !tx_full;
  assign tx_push      = bus.tx_valid && bus.tx_ready;
  assign tx_pop       = (state_q == ST_LAUNCH);
  assign rx_push      = (state_q == ST_CAPTURE);
  assign bus.rx_valid = !rx_empty;
  assign fin_rise     = bus.spi_finish && !fin_prev_q;

  assign bus.spi_start   = spi_start_q;
  assign bus.spi_data_in = spi_data_in_q;
  assign busy            = busy_q;
  assign err_timeout     = err_q;

  spi_byte_sequencer_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .data_i  (bus.tx_data),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .level_o (tx_level),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // RX space is reserved before launch, so the CAPTURE push always lands.
  spi_byte_sequencer_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .data_i  (bus.spi_data_out),
    .pop_i   (bus.rx_ready),
    .data_o  (bus.rx_data),
    .level_o (rx_level),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // Holds tx_ready low during reset; it rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en_q <= 1'b0;
    else     rdy_en_q <= 1'b1;
  end

  // Previous spi_finish level, so a finish held high counts as one event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fin_prev_q <= 1'b0;
    else     fin_prev_q <= bus.spi_finish;
  end

  // Transfer sequencer: launch, wait for finish edge or timeout, capture, gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      spi_start_q   <= 1'b0;
      spi_data_in_q <= '0;
      tmo_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      spi_start_q <= 1'b0;
      // Clear first so a timeout set later in this cycle takes priority.
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Launch only with a word to send and a guaranteed RX slot.
          if (!tx_empty && !rx_full) begin
            state_q       <= ST_LAUNCH;
            busy_q        <= 1'b1;
            spi_start_q   <= 1'b1;
            spi_data_in_q <= tx_head;
          end
        end
        ST_LAUNCH: begin
          // Counter holds cycles elapsed since the LAUNCH cycle.
          state_q   <= ST_WAIT;
          tmo_cnt_q <= TW'(1);
        end
        ST_WAIT: begin
          if (fin_rise) begin
            state_q   <= ST_CAPTURE;
            tmo_cnt_q <= '0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            tmo_cnt_q <= '0;
            err_q     <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        ST_CAPTURE: begin
          if (GAP_CYCLES == 0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= ST_GAP;
            gap_cnt_q <= '0;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            gap_cnt_q <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Purpose: self-checking bench for spi_byte_sequencer with a behavioural spi_master loopback.
// Latency: slave model raises finish slave_lat cycles after start, data_out = ~data_in.
// Backpressure: bench drives tx_valid/rx_ready directly, including full/empty corners.
module tb_spi_byte_sequencer;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int TMO   = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_clr;
  logic       busy;
  logic       err_timeout;
  logic [3:0] tx_level;
  logic [3:0] rx_level;

  spi_byte_sequencer_if #(.DATA_WIDTH(DW)) bus();

  spi_byte_sequencer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .tx_level(tx_level),
    .rx_level(rx_level), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bit slave_en   = 1'b1;
  int slave_lat  = 20;
  int slave_hold = 1;

  logic [7:0] start_dat_q[$];
  int         start_cyc_q[$];
  logic [7:0] exp_rx_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Log every spi_start with its word and cycle.
  initial forever begin
    @(negedge clk);
    if (bus.spi_start === 1'b1) begin
      start_dat_q.push_back(bus.spi_data_in);
      start_cyc_q.push_back(cyc);
    end
  end

  // spi_master model: finish after slave_lat cycles, held slave_hold cycles, reply = ~word.
  initial begin
    int         s_cnt;
    int         s_hold;
    logic [7:0] s_dat;
    s_cnt = 0; s_hold = 0; s_dat = '0;
    bus.spi_finish   = 1'b0;
    bus.spi_data_out = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        s_cnt = 0; s_hold = 0;
        bus.spi_finish = 1'b0;
      end else begin
        if (s_hold > 0) begin
          s_hold--;
          if (s_hold == 0) bus.spi_finish = 1'b0;
        end
        if (s_cnt > 0) begin
          s_cnt--;
          if (s_cnt == 0) begin
            bus.spi_data_out = ~s_dat;
            bus.spi_finish   = 1'b1;
            s_hold           = slave_hold;
          end
        end
        if (bus.spi_start === 1'b1 && slave_en) begin
          s_dat = bus.spi_data_in;
          s_cnt = slave_lat;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic push_word(input logic [7:0] w, output bit acc);
    bus.tx_valid = 1'b1;
    bus.tx_data  = w;
    acc          = bus.tx_ready;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_rx_level(input int lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_level == 4'(lvl)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.spi_start !== 1'b0) $display("FAIL rst_spi_start: got %b want 0", bus.spi_start); else n_pass++;
    n_checks++; if (bus.spi_data_in !== 8'h00) $display("FAIL rst_spi_data_in: got %h want 00", bus.spi_data_in); else n_pass++;
    n_checks++; if (bus.tx_ready !== 1'b0) $display("FAIL rst_tx_ready: got %b want 0", bus.tx_ready); else n_pass++;
    n_checks++; if (bus.rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", bus.rx_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if ({tx_level, rx_level} !== 8'h00) $display("FAIL rst_levels: got %h want 00", {tx_level, rx_level}); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL rst_err: got %b want 0", err_timeout); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.tx_ready !== 1'b1) $display("FAIL rst_release_tx_ready: got %b want 1", bus.tx_ready); else n_pass++;
  endtask

  task automatic test_loopback();
    bit ok;
    bit acc;
    int sp;
    slave_lat = 20; slave_hold = 1;
    start_dat_q.delete(); start_cyc_q.delete();
    push_word(8'hA5, acc);
    push_word(8'h9A, acc);
    wait_rx_level(2, 200, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL loop_done: rx_level %0d want 2 within budget", rx_level); else n_pass++;
    n_checks++; if (start_dat_q.size() != 2) $display("FAIL loop_nstart: got %0d want 2", start_dat_q.size()); else n_pass++;
    n_checks++; if (start_dat_q[0] !== 8'hA5) $display("FAIL loop_start0: got %h want a5", start_dat_q[0]); else n_pass++;
    n_checks++; if (start_dat_q[1] !== 8'h9A) $display("FAIL loop_start1: got %h want 9a", start_dat_q[1]); else n_pass++;
    sp = start_cyc_q[1] - start_cyc_q[0];
    n_checks++; if (sp != 3 + GAP + 20) $display("FAIL loop_spacing: got %0d want %0d", sp, 3 + GAP + 20); else n_pass++;
    n_checks++; if (bus.rx_data !== 8'h5A) $display("FAIL loop_rx0: got %h want 5a", bus.rx_data); else n_pass++;
    bus.rx_ready = 1'b1; @(negedge clk); bus.rx_ready = 1'b0;
    n_checks++; if (bus.rx_data !== 8'h65) $display("FAIL loop_rx1: got %h want 65", bus.rx_data); else n_pass++;
    bus.rx_ready = 1'b1; @(negedge clk); bus.rx_ready = 1'b0;
    n_checks++; if (bus.rx_valid !== 1'b0) $display("FAIL loop_rx_empty: rx_valid %b want 0", bus.rx_valid); else n_pass++;
  endtask

  task automatic test_rx_stall();
    logic [7:0] exp_tx[$];
    logic [7:0] w;
    logic [7:0] want;
    bit         acc;
    bit         ok;
    int         budget;
    slave_lat = 10; slave_hold = 1;
    exp_rx_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      w = 8'($urandom);
      push_word(w, acc);
      if (acc) exp_rx_q.push_back(~w);
    end
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (rx_level == 4'(DEPTH) && busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (ok !== 1'b1) $display("FAIL stall_fill: rx_level %0d busy %b want 8/0", rx_level, busy); else n_pass++;
    start_dat_q.delete(); start_cyc_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = 8'($urandom);
      push_word(w, acc);
      n_checks++; if (acc !== (i < DEPTH)) $display("FAIL stall_tx_ready[%0d]: got %b want %b", i, acc, (i < DEPTH)); else n_pass++;
      if (acc) begin exp_tx.push_back(w); exp_rx_q.push_back(~w); end
    end
    repeat (30) @(negedge clk);
    n_checks++; if (tx_level !== 4'(DEPTH)) $display("FAIL stall_tx_level: got %0d want %0d", tx_level, DEPTH); else n_pass++;
    n_checks++; if (start_dat_q.size() != 0) $display("FAIL stall_no_start: got %0d starts want 0", start_dat_q.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL stall_busy: got %b want 0", busy); else n_pass++;
    want = exp_rx_q.pop_front();
    n_checks++; if (bus.rx_data !== want) $display("FAIL stall_pop1: got %h want %h", bus.rx_data, want); else n_pass++;
    bus.rx_ready = 1'b1; @(negedge clk); bus.rx_ready = 1'b0;
    repeat (60) @(negedge clk);
    n_checks++; if (start_dat_q.size() != 1) $display("FAIL stall_one_start: got %0d want 1", start_dat_q.size()); else n_pass++;
    n_checks++; if (rx_level !== 4'(DEPTH)) $display("FAIL stall_rx_refill: got %0d want %0d", rx_level, DEPTH); else n_pass++;
    n_checks++; if (tx_level !== 4'(DEPTH - 1)) $display("FAIL stall_tx_after: got %0d want %0d", tx_level, DEPTH - 1); else n_pass++;
    budget = 0;
    while (exp_rx_q.size() > 0 && budget < 3000) begin
      if (bus.rx_valid === 1'b1) begin
        want = exp_rx_q.pop_front();
        n_checks++; if (bus.rx_data !== want) $display("FAIL stall_drain: got %h want %h", bus.rx_data, want); else n_pass++;
        bus.rx_ready = 1'b1;
      end else begin
        bus.rx_ready = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    bus.rx_ready = 1'b0;
    n_checks++; if (exp_rx_q.size() != 0) $display("FAIL stall_drain_done: %0d words left want 0", exp_rx_q.size()); else n_pass++;
    n_checks++; if (start_dat_q.size() != exp_tx.size()) $display("FAIL stall_nstart: got %0d want %0d", start_dat_q.size(), exp_tx.size()); else n_pass++;
    for (int i = 0; i < exp_tx.size() && i < start_dat_q.size(); i++) begin
      n_checks++; if (start_dat_q[i] !== exp_tx[i]) $display("FAIL stall_start_dat[%0d]: got %h want %h", i, start_dat_q[i], exp_tx[i]); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    logic [7:0] w0;
    logic [7:0] w1;
    bit         acc;
    bit         ok;
    int         t_err;
    slave_en = 1'b0; slave_lat = 10; slave_hold = 1;
    start_dat_q.delete(); start_cyc_q.delete();
    w0 = 8'($urandom); w1 = 8'($urandom);
    push_word(w0, acc);
    push_word(w1, acc);
    ok = 1'b0; t_err = 0;
    for (int i = 0; i < 1200; i++) begin
      if (err_timeout === 1'b1) begin ok = 1'b1; t_err = cyc; slave_en = 1'b1; break; end
      @(negedge clk);
    end
    slave_en = 1'b1;
    n_checks++; if (ok !== 1'b1) $display("FAIL tmo_flag: err_timeout %b want 1 within budget", err_timeout); else n_pass++;
    n_checks++; if (t_err - start_cyc_q[0] != TMO) $display("FAIL tmo_time: got %0d cycles want %0d", t_err - start_cyc_q[0], TMO); else n_pass++;
    n_checks++; if (rx_level !== 4'd0) $display("FAIL tmo_no_push: rx_level %0d want 0", rx_level); else n_pass++;
    wait_rx_level(1, 200, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL tmo_next_word: rx_level %0d want 1", rx_level); else n_pass++;
    n_checks++; if (start_dat_q.size() != 2) $display("FAIL tmo_nstart: got %0d want 2", start_dat_q.size()); else n_pass++;
    n_checks++; if (start_dat_q[1] !== w1) $display("FAIL tmo_start1: got %h want %h", start_dat_q[1], w1); else n_pass++;
    n_checks++; if (bus.rx_data !== ~w1) $display("FAIL tmo_rx: got %h want %h", bus.rx_data, ~w1); else n_pass++;
    n_checks++; if (err_timeout !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", err_timeout); else n_pass++;
    bus.rx_ready = 1'b1; @(negedge clk); bus.rx_ready = 1'b0;
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL tmo_clear: got %b want 0", err_timeout); else n_pass++;
  endtask

  task automatic test_finish_hold();
    logic [7:0] w;
    bit         acc;
    bit         ok;
    slave_lat = 8; slave_hold = 5;
    start_dat_q.delete(); start_cyc_q.delete();
    w = 8'($urandom);
    push_word(w, acc);
    wait_rx_level(1, 100, ok);
    repeat (30) @(negedge clk);
    n_checks++; if (rx_level !== 4'd1) $display("FAIL hold_one_push: rx_level %0d want 1", rx_level); else n_pass++;
    n_checks++; if (start_dat_q.size() != 1) $display("FAIL hold_nstart: got %0d want 1", start_dat_q.size()); else n_pass++;
    n_checks++; if (bus.rx_data !== ~w) $display("FAIL hold_rx: got %h want %h", bus.rx_data, ~w); else n_pass++;
    bus.rx_ready = 1'b1; @(negedge clk); bus.rx_ready = 1'b0;
    slave_hold = 1;
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic [7:0] exp_tx[$];
    logic [7:0] words[N];
    int         popped;
    int         sp;
    slave_lat  = int'($urandom_range(2, 15));
    slave_hold = int'($urandom_range(1, 4));
    start_dat_q.delete(); start_cyc_q.delete(); exp_rx_q.delete();
    for (int i = 0; i < N; i++) words[i] = 8'($urandom);
    popped = 0;
    fork
      begin
        int sent = 0;
        int t    = 0;
        while (sent < N && t < 4000) begin
          if ($urandom_range(0, 2) != 0) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = words[sent];
            if (bus.tx_ready === 1'b1) begin
              exp_tx.push_back(words[sent]);
              exp_rx_q.push_back(~words[sent]);
              sent++;
            end
          end else begin
            bus.tx_valid = 1'b0;
          end
          @(negedge clk);
          t++;
        end
        bus.tx_valid = 1'b0;
      end
      begin
        int         t = 0;
        logic [7:0] want;
        while (popped < N && t < 5000) begin
          if (bus.rx_valid === 1'b1 && $urandom_range(0, 1) == 1) begin
            want = (exp_rx_q.size() > 0) ? exp_rx_q.pop_front() : 8'hxx;
            n_checks++; if (bus.rx_data !== want) $display("FAIL rand_rx[%0d]: got %h want %h", popped, bus.rx_data, want); else n_pass++;
            bus.rx_ready = 1'b1;
            popped++;
          end else begin
            bus.rx_ready = 1'b0;
          end
          @(negedge clk);
          t++;
        end
        bus.rx_ready = 1'b0;
      end
    join
    n_checks++; if (popped != N) $display("FAIL rand_count: popped %0d want %0d", popped, N); else n_pass++;
    n_checks++; if (start_dat_q.size() != N) $display("FAIL rand_nstart: got %0d want %0d", start_dat_q.size(), N); else n_pass++;
    for (int i = 0; i < N && i < start_dat_q.size(); i++) begin
      n_checks++; if (start_dat_q[i] !== exp_tx[i]) $display("FAIL rand_start_dat[%0d]: got %h want %h", i, start_dat_q[i], exp_tx[i]); else n_pass++;
    end
    for (int i = 1; i < start_cyc_q.size(); i++) begin
      sp = start_cyc_q[i] - start_cyc_q[i-1];
      n_checks++; if (sp < 3 + GAP + slave_lat) $display("FAIL rand_spacing[%0d]: got %0d want >= %0d", i, sp, 3 + GAP + slave_lat); else n_pass++;
    end
    slave_hold = 1;
  endtask

  task automatic test_reset_mid();
    bit acc;
    bit ok;
    slave_lat = 40; slave_hold = 1;
    start_dat_q.delete(); start_cyc_q.delete();
    for (int i = 0; i < 3; i++) push_word(8'($urandom), acc);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start_dat_q.size() > 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_checks++; if (ok !== 1'b1 || busy !== 1'b1) $display("FAIL rmid_in_flight: started %b busy %b want 1/1", ok, busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.spi_start !== 1'b0 || bus.spi_data_in !== 8'h00) $display("FAIL rmid_spi: start %b data %h want 0/00", bus.spi_start, bus.spi_data_in); else n_pass++;
    n_checks++; if (bus.tx_ready !== 1'b0 || bus.rx_valid !== 1'b0) $display("FAIL rmid_hs: tx_ready %b rx_valid %b want 0/0", bus.tx_ready, bus.rx_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0 || {tx_level, rx_level} !== 8'h00 || err_timeout !== 1'b0) $display("FAIL rmid_state: busy %b levels %h err %b want 0/00/0", busy, {tx_level, rx_level}, err_timeout); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_dat_q.delete(); start_cyc_q.delete();
    repeat (100) @(negedge clk);
    n_checks++; if (start_dat_q.size() != 0) $display("FAIL rmid_no_start: got %0d starts want 0", start_dat_q.size()); else n_pass++;
    n_checks++; if (tx_level !== 4'd0 || rx_level !== 4'd0 || busy !== 1'b0) $display("FAIL rmid_after: tx %0d rx %0d busy %b want 0/0/0", tx_level, rx_level, busy); else n_pass++;
  endtask

  initial begin
    rst          = 1'b1;
    err_clr      = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_loopback();
    test_rx_stall();
    test_timeout();
    test_finish_hold();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
